spart_echo_ctrl: RTL and testbench
==================================

// Module: spart_echo_ctrl
// PURPOSE
//  Bus master that sits directly upstream of one spart instance on its iocs/iorw/ioaddr/databus port.
//  After reset it programs the spart baud divisor from br_cfg.
//  It then loops received bytes back out of the transmitter through an internal echo FIFO.
//  It is the synthesizable bring-up/loopback master for the minilab3 board and bench.
// PARAMETERS
//  CLK_HZ      50_000_000  system clock frequency; used only to compute divisor constants
//  FIFO_DEPTH  8           echo FIFO entries; power of two, >=2
// PORTS
//  clk      in     1  system clock; sole clock
//  rst      in     1  synchronous reset, active-high
//  br_cfg   in     2  baud select: 00=4800 01=9600 10=19200 11=38400
//  rda      in     1  spart receive data available
//  tbr      in     1  spart transmit buffer ready
//  iocs     out    1  spart chip select, one-cycle strobe
//  iorw     out    1  1=read, 0=write
//  ioaddr   out    2  00=TX/RX buffer, 01=status, 10=DB low, 11=DB high
//  databus  inout  8  driven only while iocs&~iorw; 'z otherwise
// BEHAVIOUR
//  Reset (rst sampled high at posedge):
//  - iocs=0, iorw=1, ioaddr=00, databus='z
//  - FIFO emptied; FSM -> CFG_LO
//  - any in-flight access is abandoned
//  Divisor: DIV = CLK_HZ/(16*baud) - 1, truncating, 16 bits.
//  - @50MHz: 650, 324, 161, 80 for br_cfg 00..11
//  FSM states: CFG_LO, CFG_HI, IDLE, RD, WR. Each non-IDLE state lasts exactly one cycle with iocs=1.
//  - CFG_LO: iorw=0, ioaddr=10, databus=DIV[7:0]; -> CFG_HI
//  - CFG_HI: iorw=0, ioaddr=11, databus=DIV[15:8]; -> IDLE
//  - IDLE: iocs=0. Next state, in priority order:
//    1) br_cfg differs from the value latched at last CFG_LO -> CFG_LO
//    2) rda & ~fifo_full -> RD
//    3) tbr & ~fifo_empty -> WR
//    4) else stay IDLE
//  - RD: iorw=1, ioaddr=00. databus is sampled at the posedge ending RD and pushed to the FIFO. -> IDLE
//  - WR: iorw=0, ioaddr=00, databus=FIFO head; head popped at the end of WR. -> IDLE
//  Latency and spacing:
//  - At least one IDLE cycle between accesses, so rda/tbr are re-sampled after the spart updates.
//  - Byte accepted in RD -> earliest WR strobe 2 cycles later.
//  br_cfg is latched in CFG_LO. A change is serviced only from IDLE; FIFO contents are preserved.
//  FIFO full: no RD issued; byte stays in the spart (back-pressure, no drop).
//  FIFO empty: no WR, even with tbr=1.
//  FIFO pointers: log2(FIFO_DEPTH)+1 bits, wrap naturally; full = MSBs differ and LSBs equal.
//  Push and pop never coincide (single bus, one access per cycle).
//  Status register (ioaddr 01) is never accessed by this block.
// CONFIGURATION
//  SPART_ECHO_UPCASE_EN
//  - defined: WR drives the byte with ASCII 'a'..'z' (0x61-0x7A) mapped to 'A'..'Z' (minus 0x20); all other bytes unchanged
//  - undefined: byte echoed verbatim
//  - FIFO always stores the raw received byte; conversion happens only on the WR databus drive
// STRUCTURE
//  Package spart_pkg:
//  - ioaddr_t enum (IO_BUF=2'b00, IO_STAT=2'b01, IO_DBL=2'b10, IO_DBH=2'b11)
//  - state_t enum
//  - function baud_div(clk_hz, br_cfg) returning logic [15:0]
//  Sub-module echo_fifo (params WIDTH=8, DEPTH): push/pop/din/dout/full/empty, sync active-high rst.
//  FSM, br_cfg latch and bus drive stay in spart_echo_ctrl.
// TESTING
//  1. Reset release, br_cfg=01: writes 0x44 to addr 10, then 0x01 to addr 11, on consecutive cycles; then idle.
//  2. Tester spart sends 0x5A: one RD strobe after rda, then one WR of 0x5A once tbr=1; tester receives 0x5A.
//  3. Send 9 bytes with tbr held 0 (FIFO_DEPTH=8): exactly 8 RD strobes; 9th byte held in spart; releasing tbr echoes all 9 in order.
//  4. br_cfg 01->11 while FIFO holds 3 bytes: writes 0x50 @10, 0x00 @11; the 3 bytes are then echoed.
//  5. SPART_ECHO_UPCASE_EN defined, send 0x61,0x7B,0x41 -> echoes 0x41,0x7B,0x41; undefined -> 0x61,0x7B,0x41.
//  6. rst pulsed during a WR cycle: next cycle iocs=0, databus='z, FIFO empty; CFG_LO/CFG_HI reissued.

Source files
------------

// File: rtl/spart_pkg.sv
// Shared types and helpers for the spart echo controller.
// Build option SPART_ECHO_UPCASE_EN uses ascii_upcase on the transmit path.
package spart_pkg;

    typedef enum logic [1:0] {
        IO_BUF  = 2'b00,
        IO_STAT = 2'b01,
        IO_DBL  = 2'b10,
        IO_DBH  = 2'b11
    } ioaddr_t;

    typedef enum logic [2:0] {
        ST_CFG_LO = 3'd0,
        ST_CFG_HI = 3'd1,
        ST_IDLE   = 3'd2,
        ST_RD     = 3'd3,
        ST_WR     = 3'd4
    } state_t;

    localparam int unsigned BAUD_BASE = 32'd4800;

    // br_cfg selects 4800 << br_cfg; divisor truncates toward zero
    function automatic logic [15:0] baud_div(input int unsigned clk_hz, input logic [1:0] br_cfg);
        int unsigned baud;
        int unsigned div;
        baud = BAUD_BASE << br_cfg;
        div  = clk_hz / (32'd16 * baud) - 32'd1;
        return div[15:0];
    endfunction

    function automatic logic [7:0] ascii_upcase(input logic [7:0] b);
        logic [7:0] r;
        if ((b >= 8'h61) && (b <= 8'h7A)) begin
            r = b - 8'h20;
        end else begin
            r = b;
        end
        return r;
    endfunction

endpackage

// File: rtl/echo_fifo.sv
// Small synchronous FIFO holding received bytes until the transmitter is ready.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module echo_fifo #(
    parameter int unsigned WIDTH = 32'd8,
    parameter int unsigned DEPTH = 32'd8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [WIDTH-1:0] mem_r [DEPTH];

    // read and write pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (push && !full) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop && !empty) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // storage array
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_r[wr_ptr_r[AW-1:0]] <= din;
        end
    end

    assign dout  = mem_r[rd_ptr_r[AW-1:0]];
    assign empty = (wr_ptr_r == rd_ptr_r);
    assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);

endmodule

// File: rtl/spart_echo_ctrl.sv
// Bus master for one spart: programs the baud divisor, then echoes received bytes.
// Define SPART_ECHO_UPCASE_EN to upper-case ASCII letters on the way out.
module spart_echo_ctrl
    import spart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 32'd50_000_000,
    parameter int unsigned FIFO_DEPTH = 32'd8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] br_cfg,
    input  logic       rda,
    input  logic       tbr,
    output logic       iocs,
    output logic       iorw,
    output logic [1:0] ioaddr,
    inout  wire  [7:0] databus
);

    state_t     state_r;
    state_t     next_state_s;
    logic       start_r;
    logic [1:0] br_lat_r;
    logic       iocs_r;
    logic       iorw_r;
    ioaddr_t    ioaddr_r;
    logic [7:0] data_r;

    logic       nxt_iocs_s;
    logic       nxt_iorw_s;
    ioaddr_t    nxt_ioaddr_s;
    logic [7:0] nxt_data_s;

    logic       fifo_push_s;
    logic       fifo_pop_s;
    logic       fifo_full_s;
    logic       fifo_empty_s;
    logic [7:0] fifo_dout_s;
    logic [7:0] wr_byte_s;
    logic [1:0] div_sel_s;
    logic [15:0] div_s;

    echo_fifo #(
        .WIDTH (32'd8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push_s),
        .pop   (fifo_pop_s),
        .din   (databus),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // The bus registers present state_r, so a RD ends (and pushes) on the edge leaving ST_RD.
    assign fifo_push_s = (state_r == ST_RD);
    assign fifo_pop_s  = (state_r == ST_WR);

`ifdef SPART_ECHO_UPCASE_EN
    assign wr_byte_s = ascii_upcase(fifo_dout_s);
`else
    assign wr_byte_s = fifo_dout_s;
`endif

    // CFG_LO uses the live br_cfg (latched on the same edge); CFG_HI uses the latch
    assign div_sel_s = (next_state_s == ST_CFG_LO) ? br_cfg : br_lat_r;
    assign div_s     = baud_div(CLK_HZ, div_sel_s);

    // next-state selection; start_r forces the first CFG_LO strobe after reset
    always_comb begin
        next_state_s = ST_IDLE;
        if (start_r) begin
            next_state_s = ST_CFG_LO;
        end else begin
            case (state_r)
                ST_CFG_LO: next_state_s = ST_CFG_HI;
                ST_CFG_HI: next_state_s = ST_IDLE;
                ST_IDLE: begin
                    if (br_cfg != br_lat_r) begin
                        next_state_s = ST_CFG_LO;
                    end else if (rda && !fifo_full_s) begin
                        next_state_s = ST_RD;
                    end else if (tbr && !fifo_empty_s) begin
                        next_state_s = ST_WR;
                    end else begin
                        next_state_s = ST_IDLE;
                    end
                end
                ST_RD:   next_state_s = ST_IDLE;
                ST_WR:   next_state_s = ST_IDLE;
                default: next_state_s = ST_IDLE;
            endcase
        end
    end

    // bus values for the state being entered
    always_comb begin
        nxt_iocs_s   = 1'b1;
        nxt_iorw_s   = 1'b0;
        nxt_ioaddr_s = IO_BUF;
        nxt_data_s   = data_r;
        case (next_state_s)
            ST_CFG_LO: begin
                nxt_ioaddr_s = IO_DBL;
                nxt_data_s   = div_s[7:0];
            end
            ST_CFG_HI: begin
                nxt_ioaddr_s = IO_DBH;
                nxt_data_s   = div_s[15:8];
            end
            ST_RD: begin
                nxt_iorw_s = 1'b1;
            end
            ST_WR: begin
                nxt_data_s = wr_byte_s;
            end
            ST_IDLE: begin
                nxt_iocs_s = 1'b0;
                nxt_iorw_s = 1'b1;
            end
            default: begin
                nxt_iocs_s = 1'b0;
                nxt_iorw_s = 1'b1;
            end
        endcase
    end

    // state, br_cfg latch and registered bus outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_CFG_LO;
            start_r  <= 1'b1;
            br_lat_r <= 2'b00;
            iocs_r   <= 1'b0;
            iorw_r   <= 1'b1;
            ioaddr_r <= IO_BUF;
            data_r   <= 8'h00;
        end else begin
            state_r  <= next_state_s;
            start_r  <= 1'b0;
            iocs_r   <= nxt_iocs_s;
            iorw_r   <= nxt_iorw_s;
            ioaddr_r <= nxt_ioaddr_s;
            data_r   <= nxt_data_s;
            if (next_state_s == ST_CFG_LO) begin
                br_lat_r <= br_cfg;
            end
        end
    end

    assign iocs    = iocs_r;
    assign iorw    = iorw_r;
    assign ioaddr  = ioaddr_r;
    assign databus = (iocs_r && !iorw_r) ? data_r : 8'bzzzz_zzzz;

endmodule

// File: tb/tb_spart_echo_ctrl.sv
// Loopback bench: a behavioural tester spart feeds bytes and scores every echo against a queue.
module tb_spart_echo_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] br_cfg;
    logic       rda;
    logic       tbr;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    wire  [7:0] databus;
    logic [7:0] drive_r;

    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    logic [9:0] cfg_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int rd_cnt   = 0;
    int wr_cnt   = 0;

    spart_echo_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .br_cfg  (br_cfg),
        .rda     (rda),
        .tbr     (tbr),
        .iocs    (iocs),
        .iorw    (iorw),
        .ioaddr  (ioaddr),
        .databus (databus)
    );

    assign databus = (iocs && iorw && (ioaddr == 2'b00)) ? drive_r : 8'bzzzz_zzzz;

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_echo(input logic [7:0] b);
`ifdef SPART_ECHO_UPCASE_EN
        if ((b >= 8'h61) && (b <= 8'h7A)) return b - 8'h20;
        return b;
`else
        return b;
`endif
    endfunction

    // one cycle: sample at negedge and act as the tester spart
    task automatic tick();
        @(negedge clk);
        if (iocs && iorw && (ioaddr == 2'b00)) begin
            rd_cnt++;
            if (rx_q.size() == 0) check_eq("rd_without_data", 32'(rx_q.size()), 32'd1);
            else drive_r = rx_q.pop_front();
        end
        if (iocs && !iorw) begin
            if (ioaddr == 2'b00) begin
                wr_cnt++;
                if (exp_q.size() == 0) check_eq("wr_unexpected", 32'(exp_q.size()), 32'd1);
                else check_eq("echo", 32'(databus), 32'(exp_q.pop_front()));
            end else begin
                cfg_q.push_back({ioaddr, databus});
            end
        end
        rda = (rx_q.size() != 0);
    endtask

    task automatic send_exp(input logic [7:0] b, input logic [7:0] e);
        rx_q.push_back(b);
        exp_q.push_back(e);
        rda = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        send_exp(b, model_echo(b));
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (((exp_q.size() != 0) || (rx_q.size() != 0)) && (n < budget)) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(n < budget), 32'd1);
        repeat (4) tick();
    endtask

    task automatic check_cfg(input string tag, input logic [7:0] lo, input logic [7:0] hi);
        check_eq({tag, "_cnt"}, 32'(cfg_q.size()), 32'd2);
        if (cfg_q.size() >= 2) begin
            check_eq({tag, "_lo"}, 32'(cfg_q.pop_front()), 32'({2'b10, lo}));
            check_eq({tag, "_hi"}, 32'(cfg_q.pop_front()), 32'({2'b11, hi}));
        end
        cfg_q.delete();
    endtask

    initial begin
        int r0;
        int w0;
        int n;
        rst = 1'b1; br_cfg = 2'b01; rda = 1'b0; tbr = 1'b0; drive_r = 8'h00;
        repeat (3) tick();
        check_eq("rst_iocs", 32'(iocs), 32'd0);
        check_eq("rst_iorw", 32'(iorw), 32'd1);
        check_eq("rst_ioaddr", 32'(ioaddr), 32'd0);

        // 1: divisor programming after reset
        rst = 1'b0;
        tick();
        check_eq("t1_lo_cs", 32'(iocs), 32'd1);
        check_eq("t1_lo_addr", 32'(ioaddr), 32'd2);
        check_eq("t1_lo_data", 32'(databus), 32'h44);
        tick();
        check_eq("t1_hi_cs", 32'(iocs), 32'd1);
        check_eq("t1_hi_addr", 32'(ioaddr), 32'd3);
        check_eq("t1_hi_data", 32'(databus), 32'h01);
        tick();
        check_eq("t1_idle_cs", 32'(iocs), 32'd0);
        repeat (3) tick();
        check_eq("t1_still_idle", 32'(iocs), 32'd0);
        cfg_q.delete();

        // 2: single byte loopback
        tbr = 1'b1; r0 = rd_cnt; w0 = wr_cnt;
        send(8'h5A);
        drain("t2_drain", 50);
        check_eq("t2_rd_count", 32'(rd_cnt - r0), 32'd1);
        check_eq("t2_wr_count", 32'(wr_cnt - w0), 32'd1);

        // 3: back-pressure with a full FIFO
        tbr = 1'b0; r0 = rd_cnt; w0 = wr_cnt;
        for (int i = 0; i < 9; i++) send(8'($urandom_range(255, 0)));
        repeat (40) tick();
        check_eq("t3_rd_count", 32'(rd_cnt - r0), 32'd8);
        check_eq("t3_held", 32'(rx_q.size()), 32'd1);
        check_eq("t3_no_wr", 32'(wr_cnt - w0), 32'd0);
        tbr = 1'b1;
        drain("t3_drain", 200);
        check_eq("t3_wr_count", 32'(wr_cnt - w0), 32'd9);

        // 4: baud change with bytes waiting in the FIFO
        tbr = 1'b0; w0 = wr_cnt;
        send(8'h31); send(8'h32); send(8'h33);
        repeat (12) tick();
        cfg_q.delete();
        br_cfg = 2'b11;
        repeat (6) tick();
        check_cfg("t4_cfg", 8'h50, 8'h00);
        check_eq("t4_no_wr", 32'(wr_cnt - w0), 32'd0);
        tbr = 1'b1;
        drain("t4_drain", 50);
        check_eq("t4_wr_count", 32'(wr_cnt - w0), 32'd3);

        // 5: upper-case option
`ifdef SPART_ECHO_UPCASE_EN
        send_exp(8'h61, 8'h41); send_exp(8'h7B, 8'h7B); send_exp(8'h41, 8'h41);
`else
        send_exp(8'h61, 8'h61); send_exp(8'h7B, 8'h7B); send_exp(8'h41, 8'h41);
`endif
        drain("t5_drain", 60);

        // 6: reset landing on a WR cycle
        tbr = 1'b0;
        send(8'hA5); send(8'h5C);
        repeat (15) tick();
        tbr = 1'b1; w0 = wr_cnt; n = 0;
        while ((wr_cnt == w0) && (n < 50)) begin
            tick();
            n++;
        end
        check_eq("t6_wr_seen", 32'(n < 50), 32'd1);
        rst = 1'b1;
        tick();
        check_eq("t6_rst_cs", 32'(iocs), 32'd0);
        rst = 1'b0;
        exp_q.delete();
        cfg_q.delete();
        tick();
        check_eq("t6_lo_cs", 32'(iocs), 32'd1);
        check_eq("t6_lo_addr", 32'(ioaddr), 32'd2);
        tick();
        check_eq("t6_hi_addr", 32'(ioaddr), 32'd3);
        check_cfg("t6_cfg", 8'h50, 8'h00);
        w0 = wr_cnt;
        repeat (10) tick();
        check_eq("t6_fifo_empty", 32'(wr_cnt - w0), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
